// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with per-register busy scoreboard and load-use stall request.
// Reads are combinational (0 cycles); writes, busy marks and pend_cnt update on rising clk.
// No internal backpressure: stall is raised to decode while any enabled source is pending.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   rd_en/rd_addr       NUM_RD packed read ports (addr i at [i*AW +: AW])
//   rd_data/rd_busy     packed read data (i at [i*XLEN +: XLEN]) and per-port pending flag
//   wr_en/addr/data     writeback port from WB (clears the busy bit)
//   iss_en/iss_addr     issue-point mark of a long-latency destination (sets the busy bit)
//   stall               OR of rd_busy
//   pend_cnt            number of busy registers
//
// Optional feature macro: RF_BYPASS_EN -- forward same-cycle writeback data to the read
// ports and suppress that port's busy flag. Without it, reads see the pre-edge array.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic                   stall,
  output logic [AW:0]            pend_cnt
);

  // Register 0 can never become busy when hardwired, so the count tops out one lower.
  localparam int PEND_MAX = (ZERO_REG != 0) ? NREGS - 1 : NREGS;

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      pend_cnt_q, pend_cnt_d;

  logic wr_zero, iss_zero, wr_ok;
  logic set_pend, clr_pend;

  assign wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
  assign iss_zero = (ZERO_REG != 0) && (iss_addr == '0);
  assign wr_ok    = wr_en && !wr_zero;

  // Busy next state: issue wins over a same-cycle writeback to the same register.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (wr_en && (wr_addr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
      if (iss_en && (iss_addr == AW'(r)) && !iss_zero) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  // Incremental count: a set only counts if the bit was clear, a clear only counts if the
  // bit was set and not re-marked by a same-cycle issue to the same register.
  assign set_pend = iss_en && !iss_zero && !busy_q[iss_addr];
  assign clr_pend = wr_en && busy_q[wr_addr] && !(iss_en && (iss_addr == wr_addr));

  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (set_pend && !clr_pend && (pend_cnt_q != (AW+1)'(PEND_MAX))) begin
      pend_cnt_d = pend_cnt_q + (AW+1)'(1);
    end else if (clr_pend && !set_pend && (pend_cnt_q != '0)) begin
      pend_cnt_d = pend_cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    assign addr    = rd_addr[gi*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
`ifdef RF_BYPASS_EN
    logic hit;
    assign hit = wr_en && (wr_addr == addr);
    assign rd_data[gi*XLEN +: XLEN] = is_zero ? '0 : (hit ? wr_data : mem_q[addr]);
    assign rd_busy[gi] = rd_en[gi] && busy_q[addr] && !hit && !is_zero;
`else
    assign rd_data[gi*XLEN +: XLEN] = is_zero ? '0 : mem_q[addr];
    assign rd_busy[gi] = rd_en[gi] && busy_q[addr] && !is_zero;
`endif
  end

  assign stall    = |rd_busy;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 3;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              stall;
  logic [AW:0]       pend_cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NRD), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .stall(stall), .pend_cnt(pend_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NRD*AW-1:0] pack(input int p0, input int p1, input int p2);
    return {AW'(p2), AW'(p1), AW'(p0)};
  endfunction

  function automatic logic [XLEN-1:0] rdat(input int port);
    return rd_data[port*XLEN +: XLEN];
  endfunction

  initial begin
    rst = 1'b1; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; iss_en = 1'b0; iss_addr = '0;
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk); rst = 1'b0; rd_addr = pack(5, 5, 5); rd_en = 3'b111; #1;
    check("rst_data0", rdat(0), 0);
    check("rst_pend", pend_cnt, 0);
    check("rst_busy", rd_busy, 0);
    check("rst_stall", stall, 0);

    // Write x5, mark x6, then reset (with a competing write/issue) clears everything
    @(negedge clk); rd_en = '0;
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; iss_en = 1'b1; iss_addr = 6;
    @(negedge clk); wr_en = 1'b0; iss_en = 1'b0; rd_addr = pack(5, 6, 0); #1;
    check("wr_x5", rdat(0), 32'hDEADBEEF);
    check("pend_x6", pend_cnt, 1);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5; wr_data = 32'h1111; iss_en = 1'b1; iss_addr = 8;
    @(negedge clk); rst = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
    rd_addr = pack(5, 8, 6); rd_en = 3'b111; #1;
    check("rstclr_data", rdat(0), 0);
    check("rstclr_pend", pend_cnt, 0);
    check("rstclr_busy", rd_busy, 0);
    check("rstclr_stall", stall, 0);

    // Zero register
    @(negedge clk); rd_en = 3'b001; rd_addr = pack(0, 0, 0);
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234; iss_en = 1'b1; iss_addr = 0; #1;
    check("x0_data_same", rdat(0), 0);
    check("x0_busy_same", rd_busy, 0);
    @(negedge clk); wr_en = 1'b0; iss_en = 1'b0; #1;
    check("x0_data", rdat(0), 0);
    check("x0_pend", pend_cnt, 0);
    check("x0_busy", rd_busy, 0);

    // Load-use stall on x7
    @(negedge clk); rd_en = '0; iss_en = 1'b1; iss_addr = 7;
    @(negedge clk); iss_en = 1'b0; rd_en = 3'b001; rd_addr = pack(7, 0, 0); #1;
    check("lu_c1_stall", stall, 1);
    check("lu_c1_busy", rd_busy, 3'b001);
    check("lu_c1_pend", pend_cnt, 1);
    @(negedge clk); #1;
    check("lu_c2_stall", stall, 1);
    @(negedge clk); wr_en = 1'b1; wr_addr = 7; wr_data = 32'h55; #1;
`ifdef RF_BYPASS_EN
    check("lu_c3_stall", stall, 0);
    check("lu_c3_data", rdat(0), 32'h55);
`else
    check("lu_c3_stall", stall, 1);
    check("lu_c3_data", rdat(0), 0);
`endif
    @(negedge clk); wr_en = 1'b0; #1;
    check("lu_c4_stall", stall, 0);
    check("lu_c4_data", rdat(0), 32'h55);
    check("lu_c4_pend", pend_cnt, 0);

    // Simultaneous issue and writeback to busy x9
    @(negedge clk); rd_en = '0; iss_en = 1'b1; iss_addr = 9;
    @(negedge clk); iss_en = 1'b0; #1;
    check("sim_pend_pre", pend_cnt, 1);
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'hA5A5; iss_en = 1'b1; iss_addr = 9;
    @(negedge clk); wr_en = 1'b0; iss_en = 1'b0; rd_en = 3'b001; rd_addr = pack(9, 0, 0); #1;
    check("sim_pend", pend_cnt, 1);
    check("sim_busy", rd_busy, 3'b001);
    check("sim_data", rdat(0), 32'hA5A5);
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99;
    @(negedge clk); wr_en = 1'b0; #1;
    check("sim_clr_pend", pend_cnt, 0);
    check("sim_clr_stall", stall, 0);
    check("sim_clr_data", rdat(0), 32'h99);

    // Multi-port: only x3 busy, ports read x3, x4, x3
    @(negedge clk); rd_en = '0; iss_en = 1'b1; iss_addr = 3;
    @(negedge clk); iss_en = 1'b0; rd_addr = pack(3, 4, 3); rd_en = 3'b011; #1;
    check("mp_busy", rd_busy, 3'b001);
    check("mp_stall", stall, 1);
    check("mp_data1", rdat(1), 0);
    rd_en = 3'b111; #1;
    check("mp_busy_all", rd_busy, 3'b101);
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h33;
    @(negedge clk); wr_en = 1'b0; #1;
    check("mp_pend", pend_cnt, 0);
    check("mp_data0", rdat(0), 32'h33);
    check("mp_data2", rdat(2), 32'h33);
    check("mp_stall_clr", stall, 0);

    // Counter bounds
    rd_en = '0;
    for (int r = 1; r < NREGS; r++) begin
      @(negedge clk); iss_en = 1'b1; iss_addr = AW'(r);
    end
    @(negedge clk); iss_en = 1'b0; #1;
    check("cnt_full", pend_cnt, 31);
    iss_en = 1'b1; iss_addr = 5;
    @(negedge clk); iss_en = 1'b0; #1;
    check("cnt_reiss", pend_cnt, 31);
    for (int r = 1; r < NREGS; r++) begin
      @(negedge clk);
      #1;
      if (r == 16) check("cnt_mid", pend_cnt, 16);
      wr_en = 1'b1; wr_addr = AW'(r); wr_data = XLEN'(r * 16);
    end
    @(negedge clk); wr_en = 1'b0; #1;
    check("cnt_empty", pend_cnt, 0);
    wr_en = 1'b1; wr_addr = 10; wr_data = 32'hAB;
    @(negedge clk); wr_en = 1'b0; rd_addr = pack(10, 31, 0); #1;
    check("cnt_no_underflow", pend_cnt, 0);
    check("cnt_x10", rdat(0), 32'hAB);
    check("cnt_x31", rdat(1), 32'h1F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register file.
- Provides NUM_RD read ports, one write port and synchronous reset of all architectural registers.
- Tracks a per-register busy scoreboard for in-flight producers (e.g. loads) and raises a stall request for decode when a source is not yet available.
- Sits in ID. It is written from WB and marked from the issue point at the ID/EX boundary.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, >= 2).
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as 0, is never written and is never busy.
- AW, $clog2(NREGS), derived localparam, address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  NUM_RD  per-port read-valid; gates busy/stall evaluation.
- rd_addr  in  NUM_RD*AW  packed source addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN].
- rd_busy  out  NUM_RD  per-port: source is pending this cycle.
- wr_en  in  1  writeback valid.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  mark a destination as pending (long-latency producer issued).
- iss_addr  in  AW  destination to mark pending.
- stall  out  1  OR over ports of rd_busy.
- pend_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset
  - rst sampled at posedge clk. On that edge all NREGS registers are cleared to 0, all busy bits cleared, and pend_cnt goes to 0.
  - rst overrides wr_en and iss_en in the same cycle.
  - After reset: rd_data = 0, rd_busy = 0, stall = 0.
- Write
  - On posedge with wr_en=1 and !(ZERO_REG && wr_addr==0), mem[wr_addr] <= wr_data.
  - Writes occur on the rising edge only, never the falling edge.
- Read
  - Combinational, zero latency.
  - Port i returns 0 if ZERO_REG && rd_addr_i==0.
  - Otherwise it returns the bypass value (see Optional Feature) or mem[rd_addr_i].
  - rd_data is driven regardless of rd_en.
- Busy bits, next state per register r:
  - If rst: 0.
  - Else if iss_en && iss_addr==r && !(ZERO_REG && r==0): 1. A new producer wins over a same-cycle writeback to the same register.
  - Else if wr_en && wr_addr==r: 0.
  - Else hold.
  - Writeback to a non-busy register is legal and leaves the bit at 0.
- pend_cnt
  - Registered count of set busy bits, updated on the same edge as the busy bits.
  - Computed as old count +1 on a set of a clear bit, -1 on a clear of a set bit, net 0 otherwise. Combined set and clear in one cycle are applied together.
  - Never wraps: max NREGS (or NREGS-1 with ZERO_REG), min 0.
- rd_busy_i = rd_en_i && busy[rd_addr_i] && !bypass_hit_i.
  - bypass_hit_i = wr_en && wr_addr==rd_addr_i when the bypass is compiled in; 0 otherwise.
  - With ZERO_REG, port address 0 is never busy.
- stall = |rd_busy. Combinational; decode holds IF/ID and injects a bubble while stall=1.
- Multiple read ports to the same address return identical data and busy.
- iss_en to an already-busy register keeps it busy; pend_cnt unchanged.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - A same-cycle write to a read address is forwarded: rd_data_i = wr_data when wr_en && wr_addr==rd_addr_i (subject to ZERO_REG).
  - That port's rd_busy is suppressed, so a writeback clearing a busy register costs 0 stall cycles.
- Not defined:
  - Reads return the pre-edge array value.
  - A busy register being written this cycle still stalls. Data and busy resolve on the next cycle, costing 1 extra stall cycle.
  - No forwarding mux is synthesised.

Test Plan:
- Reset clear: write x5=0xDEADBEEF, assert rst 1 cycle -> rd_data(x5)=0, pend_cnt=0, stall=0 next cycle.
- Zero register (ZERO_REG=1): wr_en x0=0x1234, iss_en x0 -> rd_data(x0)=0, pend_cnt stays 0, rd_busy=0.
- Load-use stall: iss_en x7 at cycle 0; port0 reads x7 with rd_en=1 at cycle 1 -> stall=1, pend_cnt=1. wr_en x7=0x55 at cycle 3:
  - with RF_BYPASS_EN: stall=0 and rd_data=0x55 in cycle 3.
  - without RF_BYPASS_EN: stall=1 in cycle 3, then 0 with rd_data=0x55 in cycle 4.
- Simultaneous issue and writeback same register: x9 busy; in one cycle wr_en x9 and iss_en x9 -> x9 stays busy, pend_cnt unchanged (1), data updated.
- Multi-port (NUM_RD=3): busy x3 only; ports read x3, x4, x3 with rd_en=1,1,0 -> rd_busy=3'b001, stall=1.
- Counter bounds: iss_en every register 1..31 on consecutive cycles -> pend_cnt=31. Writeback all -> pend_cnt back to 0, no underflow on an extra writeback to an idle register.
